// File: rtl/col_block_result_serializer.sv
// Serializes one wide beat of bf16 column-block results into narrow slices,
// tagging each slice with its first row, a last-slice flag, a NaN flag and a beat index.
module col_block_result_serializer #(
    parameter int PARALLEL_ROW   = 32,
    parameter int FP_WIDTH       = 16,
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 7,
    parameter int SIGN_WIDTH     = 1,
    parameter int OUT_LANES      = 4,
    parameter int BEAT_CNT_WIDTH = 8,
    localparam int NUM_SLICES    = PARALLEL_ROW / OUT_LANES,
    localparam int ROW_IDX_W     = $clog2(PARALLEL_ROW)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PARALLEL_ROW*FP_WIDTH-1:0] fp_col_block_result,
    input  logic                             fp_col_block_result_vld,
    output logic                             fp_col_block_result_rdy,
    output logic [OUT_LANES*FP_WIDTH-1:0]    out_data,
    output logic                             out_vld,
    input  logic                             out_rdy,
    output logic [ROW_IDX_W-1:0]             out_row_idx,
    output logic                             out_last,
    output logic                             out_nan,
    output logic [BEAT_CNT_WIDTH-1:0]        out_beat_cnt
);

    localparam int SLICE_W    = OUT_LANES * FP_WIDTH;
    localparam int SC_W       = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int LANE_SHIFT = $clog2(OUT_LANES);
    localparam logic [SC_W-1:0] LAST_SLICE = SC_W'(NUM_SLICES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_e;

    state_e                           state_q;
    logic [PARALLEL_ROW*FP_WIDTH-1:0] beatReg_q;
    logic [SC_W-1:0]                  sliceCnt_q;
    logic [SC_W-1:0]                  sliceCnt_d;
    logic [BEAT_CNT_WIDTH-1:0]        beatCnt_q;
    logic [BEAT_CNT_WIDTH-1:0]        beatCnt_d;

    logic             full;
    logic             inFire;
    logic             outFire;
    logic             lastFire;
    logic [SLICE_W-1:0] sliceData;
    logic             sliceNan;

    assign full       = (state_q == BUSY);
    assign out_last   = full && (sliceCnt_q == LAST_SLICE);
    assign outFire    = full && out_rdy;
    assign lastFire   = outFire && out_last;
    // Ready looks through to out_rdy so a new beat can load on the final slice's handshake.
    assign fp_col_block_result_rdy = !full || lastFire;
    assign inFire     = fp_col_block_result_vld && fp_col_block_result_rdy;
    assign sliceCnt_d = sliceCnt_q + SC_W'(1);
    assign beatCnt_d  = beatCnt_q + BEAT_CNT_WIDTH'(1);

    always_comb begin
        sliceData = '0;
        for (int s = 0; s < NUM_SLICES; s++) begin
            if (sliceCnt_q == SC_W'(s)) begin
                sliceData = beatReg_q[s*SLICE_W +: SLICE_W];
            end
        end
    end

    // A lane is NaN when its exponent is all ones and its mantissa is nonzero; infinity is not.
    always_comb begin
        sliceNan = 1'b0;
        for (int j = 0; j < OUT_LANES; j++) begin
            if ((&sliceData[j*FP_WIDTH + FP_WIDTH - SIGN_WIDTH - 1 -: EXP_WIDTH]) &&
                (|sliceData[j*FP_WIDTH +: MANTISSA_WIDTH])) begin
                sliceNan = 1'b1;
            end
        end
    end

    assign out_vld      = full;
    assign out_data     = sliceData;
    assign out_nan      = full && sliceNan;
    assign out_row_idx  = ROW_IDX_W'(sliceCnt_q) << LANE_SHIFT;
    assign out_beat_cnt = beatCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            beatReg_q  <= '0;
            sliceCnt_q <= '0;
            beatCnt_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (inFire) begin
                        beatReg_q  <= fp_col_block_result;
                        sliceCnt_q <= '0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (lastFire) begin
                        beatCnt_q  <= beatCnt_d;
                        sliceCnt_q <= '0;
                        if (inFire) begin
                            beatReg_q <= fp_col_block_result;
                        end else begin
                            state_q <= EMPTY;
                        end
                    end else if (outFire) begin
                        sliceCnt_q <= sliceCnt_d;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/col_block_result_serializer.md
# col_block_result_serializer

Downstream of the column-block accumulation stage. Accepts one wide beat of `PARALLEL_ROW` bf16 column-block results via valid/ready and replays it as `PARALLEL_ROW/OUT_LANES` narrow slices to the writeback/output path. Each slice is tagged with its starting row index, a last-slice flag, a NaN flag and a running beat count. Single holding register with last-slice bypass, so back-to-back beats stream without bubbles.

## Interface
- `PARALLEL_ROW`, 32, rows per input beat.
- `FP_WIDTH`, 16, bits per result.
- `EXP_WIDTH`, 8, exponent field width.
- `MANTISSA_WIDTH`, 7, mantissa field width.
- `SIGN_WIDTH`, 1, sign field width.
- `OUT_LANES`, 4, results per output slice. Power of two; divides `PARALLEL_ROW`.
- `BEAT_CNT_WIDTH`, 8, width of the beat counter.
- Derived: `NUM_SLICES = PARALLEL_ROW/OUT_LANES`, `ROW_IDX_W = $clog2(PARALLEL_ROW)`.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fp_col_block_result`  in  `PARALLEL_ROW*FP_WIDTH`  input beat; row r at `[r*FP_WIDTH +: FP_WIDTH]`.
- `fp_col_block_result_vld`  in  1  input valid.
- `fp_col_block_result_rdy`  out  1  input ready.
- `out_data`  out  `OUT_LANES*FP_WIDTH`  slice; lane j = row `out_row_idx+j`.
- `out_vld`  out  1  slice valid.
- `out_rdy`  in  1  slice ready.
- `out_row_idx`  out  `ROW_IDX_W`  first row of the current slice.
- `out_last`  out  1  current slice is the final slice of its beat.
- `out_nan`  out  1  at least one lane of `out_data` is NaN.
- `out_beat_cnt`  out  `BEAT_CNT_WIDTH`  index of the beat currently being emitted.

## Operation
- State: `full` (EMPTY/BUSY), `beat_reg` (`PARALLEL_ROW*FP_WIDTH`), `slice_cnt` (`$clog2(NUM_SLICES)`, min 1 bit), `beat_cnt`.
- Handshakes: in_fire = `vld & rdy`; out_fire = `out_vld & out_rdy`; last_fire = out_fire & `out_last`.
- `fp_col_block_result_rdy = ~full | last_fire`. This is combinational on `out_rdy` by design.
- EMPTY: on in_fire, load `beat_reg`, set `slice_cnt=0`, go BUSY.
- BUSY:
  - out_fire and not last → `slice_cnt+1`.
  - last_fire with in_fire in the same cycle → reload `beat_reg`, `slice_cnt=0`, stay BUSY.
  - last_fire without in_fire → EMPTY, `slice_cnt=0`.
  - `beat_cnt` increments on every last_fire and wraps modulo 2^`BEAT_CNT_WIDTH`.
- `out_vld = full`.
- `out_data = beat_reg[slice_cnt*OUT_LANES*FP_WIDTH +: OUT_LANES*FP_WIDTH]`.
- `out_row_idx = slice_cnt*OUT_LANES`.
- `out_last = full & (slice_cnt == NUM_SLICES-1)`.
- `out_beat_cnt = beat_cnt`.
- NaN test per lane: exponent field (bits `[FP_WIDTH-SIGN_WIDTH-1 -: EXP_WIDTH]`) all ones AND mantissa (`[MANTISSA_WIDTH-1:0]`) nonzero. `out_nan` = OR over lanes, gated by `full`. Infinity (mantissa 0) is not NaN.
- Data is passed through bit-exact. No rounding or canonicalization.

## Timing
- Reset (async assert, sync-to-clk deassert use):
  - `full=0`, `slice_cnt=0`, `beat_cnt=0`, `beat_reg=0`.
  - Outputs: `out_vld=0`, `out_data=0`, `out_row_idx=0`, `out_last=0`, `out_nan=0`, `out_beat_cnt=0`, `fp_col_block_result_rdy=1`.
- Latency: beat accepted on edge N → slice 0 presented with `out_vld=1` after edge N (same cycle as N+1's setup). With `out_rdy` held high, slice k is presented in cycle N+1+k.
- Throughput: one slice per cycle. With continuous input and `out_rdy=1`, the input is accepted once every `NUM_SLICES` cycles with zero output bubbles.
- Output hold: while `out_vld & ~out_rdy`, all `out_*` stay stable and the input is not ready while BUSY.
- `out_vld` never drops without out_fire.
- Reset mid-beat: remaining slices are discarded, `beat_cnt` returns to 0, and the block is ready next cycle.
- `NUM_SLICES==1`: `out_last=full`, and every out_fire is a last_fire.

## Test plan
- Single beat, defaults: row r = `16'h3F80+r`, `out_rdy=1` → 8 slices on consecutive cycles; `out_row_idx` = 0,4,…,28; slice 0 = {3F83,3F82,3F81,3F80}; `out_last` only on the 8th; then `out_vld=0`; `out_beat_cnt=0` throughout, 1 afterwards.
- Back-to-back: two beats offered continuously → 16 consecutive slices with no gap; rdy is high at reset and then only in the cycle of beat 0's last_fire; `out_beat_cnt` reads 0 then 1.
- Backpressure: drop `out_rdy` for 3 cycles while slice 2 is presented → `out_data`/`out_row_idx`=8/`out_nan` are unchanged; input rdy=0; slice 3 follows the release.
- NaN: row 5 = `16'h7FC1`, row 9 = `16'h7F80` (inf), all others `16'h0000` → `out_nan=1` only on slice 1; slice 2 = 0.
- Counter wrap: `BEAT_CNT_WIDTH=2`, 5 beats → `out_beat_cnt` = 0,1,2,3,0.
- Reset mid-beat: assert `rst_n=0` during slice 3 → all outputs reach reset values immediately; after release, a new beat emits from `out_row_idx=0` with `out_beat_cnt=0`.
